// File: rtl/src_ctrl_pkg.sv
// Shared definitions for the SRC hardwired control sequencer:
// opcodes, ALU operation codes, sequencer states and the control strobe bundle.
package src_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NONE  = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0110;
  localparam logic [3:0] ALU_OR    = 4'b0111;
  localparam logic [3:0] ALU_INCPC = 4'b1011;
  localparam logic [3:0] ALU_BR    = 4'b1111;

  typedef enum logic [3:0] {
    S_RST, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic mdr_read;
    logic wren;
    logic ir_in;
    logic y_in;
    logic zlow_in;
    logic zlow_out;
    logic zhigh_in;
    logic zhigh_out;
    logic c_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic conff_in;
    logic hi_in;
    logic lo_in;
    logic hi_out;
    logic lo_out;
    logic inport_out;
    logic op_in;
    logic ip_in;
  } ctl_t;

  // Register-register and immediate forms share one ALU code per operation.
  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR,  OP_ORI:  return ALU_OR;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/src_ctrl_decode.sv
// Combinational step decoder: (state, opcode, con) -> control strobes,
// ALU select and next sequencer state.
module src_ctrl_decode
  import src_ctrl_pkg::*;
#(
  parameter int OPW = 5,
  parameter int ASW = 4
) (
  input  state_t           state_i,
  input  logic [OPW-1:0]   opcode_i,
  input  logic             con_i,
  output ctl_t             ctl_o,
  output logic [ASW-1:0]   alu_sel_o,
  output state_t           state_nxt_o
);

  logic last_step;

  always_comb begin
    ctl_o       = '0;
    alu_sel_o   = ALU_NONE;
    state_nxt_o = state_i;
    last_step   = 1'b0;
    case (state_i)
      S_RST:  state_nxt_o = T0;
      S_HALT: state_nxt_o = S_HALT;
      T0: begin
        state_nxt_o   = T1;
        ctl_o.pc_out  = 1'b1;
        ctl_o.mar_in  = 1'b1;
        ctl_o.zlow_in = 1'b1;
        alu_sel_o     = ALU_INCPC;
      end
      T1: begin
        state_nxt_o    = T2;
        ctl_o.zlow_out = 1'b1;
        ctl_o.pc_in    = 1'b1;
        ctl_o.mdr_read = 1'b1;
        ctl_o.mdr_in   = 1'b1;
      end
      T2: begin
        state_nxt_o   = T3;
        ctl_o.mdr_out = 1'b1;
        ctl_o.ir_in   = 1'b1;
      end
      T3: begin
        state_nxt_o = T4;
        case (opcode_i)
          OP_LD, OP_LDI, OP_ST: begin
            ctl_o.grb = 1'b1; ctl_o.ba_out = 1'b1; ctl_o.y_in = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            ctl_o.grb = 1'b1; ctl_o.r_out = 1'b1; ctl_o.y_in = 1'b1;
          end
          OP_BR: begin
            ctl_o.gra = 1'b1; ctl_o.r_out = 1'b1; ctl_o.conff_in = 1'b1;
          end
          OP_JR: begin
            ctl_o.gra = 1'b1; ctl_o.r_out = 1'b1; ctl_o.pc_in = 1'b1;
            last_step = 1'b1;
          end
          OP_JAL: begin
            ctl_o.grb = 1'b1; ctl_o.r_in = 1'b1; ctl_o.pc_out = 1'b1;
          end
          OP_IN: begin
            ctl_o.gra = 1'b1; ctl_o.r_in = 1'b1; ctl_o.inport_out = 1'b1;
            last_step = 1'b1;
          end
          OP_OUT: begin
            ctl_o.gra = 1'b1; ctl_o.r_out = 1'b1; ctl_o.op_in = 1'b1;
            last_step = 1'b1;
          end
          OP_MFHI: begin
            ctl_o.gra = 1'b1; ctl_o.r_in = 1'b1; ctl_o.hi_out = 1'b1;
            last_step = 1'b1;
          end
          OP_MFLO: begin
            ctl_o.gra = 1'b1; ctl_o.r_in = 1'b1; ctl_o.lo_out = 1'b1;
            last_step = 1'b1;
          end
          OP_HALT: state_nxt_o = S_HALT;
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        state_nxt_o = T5;
        case (opcode_i)
          OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI: begin
            ctl_o.c_out = 1'b1; ctl_o.zlow_in = 1'b1;
            alu_sel_o   = alu_of(opcode_i);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctl_o.grc = 1'b1; ctl_o.r_out = 1'b1; ctl_o.zlow_in = 1'b1;
            alu_sel_o = alu_of(opcode_i);
          end
          OP_BR: begin
            ctl_o.pc_out = 1'b1; ctl_o.y_in = 1'b1;
          end
          OP_JAL: begin
            ctl_o.gra = 1'b1; ctl_o.r_out = 1'b1; ctl_o.pc_in = 1'b1;
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T5: begin
        state_nxt_o = T6;
        case (opcode_i)
          OP_LD, OP_ST: begin
            ctl_o.zlow_out = 1'b1; ctl_o.mar_in = 1'b1;
          end
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            ctl_o.zlow_out = 1'b1; ctl_o.gra = 1'b1; ctl_o.r_in = 1'b1;
            last_step = 1'b1;
          end
          OP_BR: begin
            ctl_o.c_out = 1'b1; ctl_o.zlow_in = 1'b1;
            alu_sel_o   = ALU_BR;
          end
          default: last_step = 1'b1;
        endcase
      end
      T6: begin
        state_nxt_o = T7;
        case (opcode_i)
          OP_LD: begin
            ctl_o.mdr_read = 1'b1; ctl_o.mdr_in = 1'b1;
          end
          OP_ST: begin
            ctl_o.gra = 1'b1; ctl_o.r_out = 1'b1; ctl_o.mdr_in = 1'b1;
          end
          OP_BR: begin
            // Branch taken only when the CON flop is set; otherwise PC keeps PC+1.
            ctl_o.zlow_out = 1'b1;
            ctl_o.pc_in    = con_i;
            last_step      = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T7: begin
        last_step = 1'b1;
        case (opcode_i)
          OP_LD: begin
            ctl_o.mdr_out = 1'b1; ctl_o.gra = 1'b1; ctl_o.r_in = 1'b1;
          end
          OP_ST:   ctl_o.wren = 1'b1;
          default: ;
        endcase
      end
      default: state_nxt_o = S_RST;
    endcase
    if (last_step) state_nxt_o = T0;
  end

endmodule

// File: rtl/src_control_unit.sv
// Hardwired control sequencer for the SRC datapath: fetch, decode and execute
// steps T0..T7, with a halt state released only by reset.
module src_control_unit
  import src_ctrl_pkg::*;
#(
  parameter int OPW = 5,
  parameter int ASW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    ir,
  input  logic           con,
  output logic           run,
  output logic           PCout,
  output logic           PCin,
  output logic           MARin,
  output logic           MDRin,
  output logic           MDRout,
  output logic           MDRread,
  output logic           wren,
  output logic           IRin,
  output logic           Yin,
  output logic           Zlowin,
  output logic           ZLowout,
  output logic           Zhighin,
  output logic           ZHighout,
  output logic           Cout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           conffin,
  output logic           HIin,
  output logic           LOin,
  output logic           HIout,
  output logic           LOout,
  output logic           InPortout,
  output logic           OPin,
  output logic           IPin,
  output logic [ASW-1:0] ALUselect
);

  state_t state_q, state_d;
  logic   run_q, run_d;
  ctl_t   ctl;
  logic   unused_ir;

  assign unused_ir = ^ir[31-OPW:0];

  src_ctrl_decode #(
    .OPW (OPW),
    .ASW (ASW)
  ) u_decode (
    .state_i     (state_q),
    .opcode_i    (ir[31 -: OPW]),
    .con_i       (con),
    .ctl_o       (ctl),
    .alu_sel_o   (ALUselect),
    .state_nxt_o (state_d)
  );

  // run tracks the state being entered, so it drops together with entry to halt.
  always_comb begin
    run_d = 1'b1;
    if (state_d == S_RST || state_d == S_HALT) run_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign run       = run_q;
  assign PCout     = ctl.pc_out;
  assign PCin      = ctl.pc_in;
  assign MARin     = ctl.mar_in;
  assign MDRin     = ctl.mdr_in;
  assign MDRout    = ctl.mdr_out;
  assign MDRread   = ctl.mdr_read;
  assign wren      = ctl.wren;
  assign IRin      = ctl.ir_in;
  assign Yin       = ctl.y_in;
  assign Zlowin    = ctl.zlow_in;
  assign ZLowout   = ctl.zlow_out;
  assign Zhighin   = ctl.zhigh_in;
  assign ZHighout  = ctl.zhigh_out;
  assign Cout      = ctl.c_out;
  assign Gra       = ctl.gra;
  assign Grb       = ctl.grb;
  assign Grc       = ctl.grc;
  assign Rin       = ctl.r_in;
  assign Rout      = ctl.r_out;
  assign BAout     = ctl.ba_out;
  assign conffin   = ctl.conff_in;
  assign HIin      = ctl.hi_in;
  assign LOin      = ctl.lo_in;
  assign HIout     = ctl.hi_out;
  assign LOout     = ctl.lo_out;
  assign InPortout = ctl.inport_out;
  assign OPin      = ctl.op_in;
  assign IPin      = ctl.ip_in;

endmodule
